uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmit line between two byte requesters and sequences each frame using the 16x oversampling clock from the UART clock divider. Arbitrates round-robin, accepts one byte per grant, serializes it LSB-first as start, data and stop bits, each lasting TICKS_PER_BIT sample ticks. Sits between the peripheral bus and the UART TX pin, next to the clock divider.

## Interface

- TICKS_PER_BIT, 16: sample ticks per serial bit.
- DATA_BITS, 8: data bits per frame.
- sysclk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- uart_clk  in  1  16x sample clock from the divider; a level signal generated in the sysclk domain.
- req0  in  1  requester 0 has a byte pending; held until ack0.
- data0  in  DATA_BITS  requester 0 byte; stable while req0 is high.
- req1  in  1  requester 1 has a byte pending; held until ack1.
- data1  in  DATA_BITS  requester 1 byte.
- ack0  out  1  one-cycle pulse when the requester 0 byte is latched.
- ack1  out  1  one-cycle pulse when the requester 1 byte is latched.
- owner  out  1  index of the requester whose frame is in flight or was last sent.
- busy  out  1  frame in progress.
- tx  out  1  serial output; idle level is 1.

## Operation

- Tick: uart_clk_d is uart_clk registered. tick = uart_clk & ~uart_clk_d. No synchronizer is used because uart_clk is already in the sysclk domain. At 50 MHz and 9600 baud, one tick occurs every 326 sysclk cycles.
- States:
  - IDLE: no frame in progress.
  - START: start bit.
  - DATA: data bits, bit_idx 0..DATA_BITS-1.
  - PARITY: present only when the macro is defined.
  - STOP: stop bit.
- IDLE, one request high: grant that requester.
- IDLE, both requests high: grant the requester that is not last_owner.
- IDLE, grant taken:
  - latch the selected data into shift_reg;
  - pulse the matching ack for exactly one cycle;
  - set owner and last_owner to the granted index;
  - go to START with tick_cnt = 0.
- IDLE, no request: stay in IDLE. A request that is withdrawn before ack is simply not sent.
- Bit advance: tick_cnt counts ticks within the current bit. When tick is high and tick_cnt == TICKS_PER_BIT-1:
  - clear tick_cnt;
  - advance to the next bit or state.
- Non-tick cycles hold tick_cnt.
- DATA: tx = shift_reg[0]. On each bit advance, shift_reg shifts right by 1. Leave DATA after bit DATA_BITS-1.
- STOP: tx = 1. On the bit advance, go to IDLE.
- tx is a register. Its value for each state appears on the cycle after that state is entered.
- tick_cnt width is clog2(TICKS_PER_BIT). bit_idx width is clog2(DATA_BITS). Both wrap-free: they are cleared at every state change.

## Timing

- Reset values: tx=1, busy=0, ack0=0, ack1=0, owner=0, last_owner=1, state IDLE. last_owner=1 makes requester 0 win the first simultaneous request.
- Acceptance: ack is high in the cycle the grant is registered.
- busy and tx=0 (start bit) begin on the next cycle.
- Bit length: a bit ends on the TICKS_PER_BIT-th tick after it starts. The first bit may be short by up to one tick period (1/16 bit); this is accepted jitter.
- Frame length: (DATA_BITS+2)×16 ticks, which is 52160 sysclk cycles ±326 in the default system.
- End of frame: busy drops in the cycle the state returns to IDLE.
- Pending request: the next grant comes one cycle after return to IDLE, so there is at least one idle cycle between frames.
- A request arriving during busy waits. Its data must be held; it is not sampled until acceptance.
- Reset in any state takes effect on the next edge:
  - the frame is aborted and tx returns to 1;
  - no ack is issued;
  - a held request is re-arbitrated from the reset state.

## Configuration

- UART_TX_PARITY_EN defined:
  - the PARITY state is inserted between DATA and STOP;
  - tx = even parity, the XOR of the latched byte, computed at acceptance;
  - the frame is DATA_BITS+3 bits.
- UART_TX_PARITY_EN undefined:
  - no PARITY state and no parity logic;
  - DATA goes directly to STOP.

## Test plan

- Reset held 3 cycles with both requests high → tx=1, busy=0, ack0=ack1=0, owner=0 throughout.
- req0 with data0=0x55 → ack0 pulses exactly one cycle. tx then sends 0, 1,0,1,0,1,0,1,0, 1, each bit 16 ticks. busy then falls and owner=0.
- req0=0xA5 and req1=0x3C raised in the same cycle → the 0xA5 frame is sent first, then 0x3C. owner goes 0 then 1, with one idle cycle between frames.
- Both requests held continuously for 4 frames → grant order 0,1,0,1, each ack a single-cycle pulse.
- Reset asserted during data bit 3 → next cycle tx=1, busy=0, state IDLE. A following req1=0xFF sends a complete, uncorrupted frame.
- With UART_TX_PARITY_EN, req0=0x07 → parity bit 1 and an 11-bit frame. With 0x03 → parity bit 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX line between two byte requesters; frames are timed
// by the 16x sample tick. Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_arbiter #(
   parameter int TICKS_PER_BIT = 16,
   parameter int DATA_BITS     = 8
) (
   input  logic                 sysclk,
   input  logic                 reset,
   input  logic                 uart_clk,
   input  logic                 req0,
   input  logic [DATA_BITS-1:0] data0,
   input  logic                 req1,
   input  logic [DATA_BITS-1:0] data1,
   output logic                 ack0,
   output logic                 ack1,
   output logic                 owner,
   output logic                 busy,
   output logic                 tx
);

   localparam int CNT_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic                   uart_clk_q;
   logic [CNT_W-1:0]       tick_cnt_q, tick_cnt_d;
   logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   owner_q, owner_d;
   logic                   last_owner_q, last_owner_d;
   logic                   ack0_q, ack0_d;
   logic                   ack1_q, ack1_d;
   logic                   busy_q, busy_d;
   logic                   tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
   logic                   parity_q, parity_d;
`endif

   logic                   tick;
   logic                   bit_done;
   logic                   grant_idx;
   logic [DATA_BITS-1:0]   sel_data;

   // uart_clk is already in the sysclk domain, so a single edge-detect flop suffices.
   assign tick      = uart_clk & ~uart_clk_q;
   assign bit_done  = tick && (tick_cnt_q == CNT_LAST);
   assign grant_idx = (req0 && req1) ? ~last_owner_q : req1;
   assign sel_data  = grant_idx ? data1 : data0;

   always_comb begin
      state_d      = state_q;
      tick_cnt_d   = tick_cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d     = parity_q;
`endif

      if (state_q != S_IDLE && tick) begin
         tick_cnt_d = bit_done ? '0 : tick_cnt_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               shift_d      = sel_data;
               ack0_d       = ~grant_idx;
               ack1_d       = grant_idx;
               owner_d      = grant_idx;
               last_owner_d = grant_idx;
               tick_cnt_d   = '0;
               bit_idx_d    = '0;
               state_d      = S_START;
`ifdef UART_TX_PARITY_EN
               parity_d     = ^sel_data;
`endif
            end
         end
         S_START: begin
            if (bit_done) begin
               state_d   = S_DATA;
               bit_idx_d = '0;
            end
         end
         S_DATA: begin
            if (bit_done) begin
               shift_d = shift_q >> 1;
               if (bit_idx_q == IDX_LAST) begin
                  bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d   = S_PARITY;
`else
                  state_d   = S_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_done) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            if (bit_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // tx is registered from the current state, so each level lags state entry by one cycle.
      case (state_q)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = parity_q;
`endif
         default:  tx_d = 1'b1;
      endcase

      busy_d = (state_q != S_IDLE) && (state_d != S_IDLE);
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         uart_clk_q   <= 1'b0;
         tick_cnt_q   <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         busy_q       <= 1'b0;
         tx_q         <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         uart_clk_q   <= uart_clk;
         tick_cnt_q   <= tick_cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         busy_q       <= busy_d;
         tx_q         <= tx_d;
`ifdef UART_TX_PARITY_EN
         parity_q     <= parity_d;
`endif
      end
   end

   assign ack0  = ack0_q;
   assign ack1  = ack1_q;
   assign owner = owner_q;
   assign busy  = busy_q;
   assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester drivers feed an expected-frame queue, a serial monitor
// decodes tx and checks each frame against it. Parity checks follow UART_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

   localparam int TPB      = 16;
   localparam int DB       = 8;
   localparam int TICK_DIV = 4;
   localparam int BIT_CYC  = TPB * TICK_DIV;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS    = DB + 3;
`else
   localparam int NBITS    = DB + 2;
`endif
   localparam int FRAME_CYC = NBITS * BIT_CYC;

   logic          sysclk   = 1'b0;
   logic          uart_clk = 1'b0;
   logic [1:0]    div_cnt  = 2'd0;
   logic          reset, req0, req1;
   logic [DB-1:0] data0, data1;
   logic          ack0, ack1, owner, busy, tx;

   int            checks = 0;
   int            errors = 0;
   logic [DB:0]   exp_q[$];
   logic          mdl_last;
   logic [DB-1:0] tab0[4];
   logic [DB-1:0] tab1[4];

   uart_tx_arbiter #(.TICKS_PER_BIT(TPB), .DATA_BITS(DB)) dut (
      .sysclk  (sysclk),
      .reset   (reset),
      .uart_clk(uart_clk),
      .req0    (req0),
      .data0   (data0),
      .req1    (req1),
      .data1   (data1),
      .ack0    (ack0),
      .ack1    (ack1),
      .owner   (owner),
      .busy    (busy),
      .tx      (tx)
   );

   // Clocks: sysclk 100 MHz, sample tick once every TICK_DIV sysclk cycles.
   always #5 sysclk = ~sysclk;
   always @(posedge sysclk) begin
      div_cnt  <= div_cnt + 2'd1;
      uart_clk <= div_cnt[1];
   end

   // Serial monitor / scoreboard.
   task automatic decode_frame();
      logic [NBITS-1:0] bits;
      logic [DB:0]      exp;
      logic [DB-1:0]    rx_byte;
      int               cyc;
      int               k;
      bit               done;
      bit               aborted;
      bits = '0; cyc = 0; k = 0; done = 0; aborted = 0;
      while (!done && !aborted && cyc < 2 * FRAME_CYC) begin
         if (k < NBITS && cyc == BIT_CYC / 2 + k * BIT_CYC) begin
            bits[k] = tx;
            k++;
         end
         @(negedge sysclk);
         cyc++;
         if (reset === 1'b1) aborted = 1;
         else if (busy === 1'b0) done = 1;
      end
      if (aborted) return;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL frame_end: busy=%b after %0d cycles, required 0", busy, cyc);
         return;
      end
      rx_byte = bits[DB:1];
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_frame: byte %h owner %b, required no frame", rx_byte, owner);
         return;
      end
      exp = exp_q.pop_front();
      checks++;
      if (bits[0] !== 1'b0) begin
         errors++;
         $display("FAIL start_bit: got %b, required 0", bits[0]);
      end
      checks++;
      if (rx_byte !== exp[DB-1:0]) begin
         errors++;
         $display("FAIL data_byte: got %h, required %h", rx_byte, exp[DB-1:0]);
      end
`ifdef UART_TX_PARITY_EN
      checks++;
      if (bits[DB+1] !== ^exp[DB-1:0]) begin
         errors++;
         $display("FAIL parity_bit: got %b, required %b for byte %h", bits[DB+1], ^exp[DB-1:0], exp[DB-1:0]);
      end
`endif
      checks++;
      if (bits[NBITS-1] !== 1'b1) begin
         errors++;
         $display("FAIL stop_bit: got %b, required 1", bits[NBITS-1]);
      end
      checks++;
      if (owner !== exp[DB]) begin
         errors++;
         $display("FAIL frame_owner: got %b, required %b", owner, exp[DB]);
      end
      checks++;
      if (cyc < FRAME_CYC - TICK_DIV || cyc > FRAME_CYC - 1) begin
         errors++;
         $display("FAIL frame_length: got %0d cycles, required %0d..%0d", cyc, FRAME_CYC - TICK_DIV, FRAME_CYC - 1);
      end
   endtask

   initial begin
      forever begin
         @(negedge sysclk);
         if (reset !== 1'b1 && tx === 1'b0) decode_frame();
      end
   end

   // Drivers.
   task automatic reset_dut();
      @(posedge sysclk); #2;
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
      repeat (2) @(posedge sysclk);
      #2 reset = 1'b0;
      mdl_last = 1'b1;
   endtask

   // Requesters hold req and present the next table byte right after each ack.
   task automatic serve(input int n0, input int n1);
      int   i0, i1, run, n;
      logic win, r0, r1, seen0, seen1;
      i0 = 0; i1 = 0;
      @(posedge sysclk); #2;
      req0 = (n0 > 0); req1 = (n1 > 0);
      data0 = tab0[0]; data1 = tab1[0];
      for (int g = 0; g < n0 + n1; g++) begin
         r0 = (i0 < n0);
         r1 = (i1 < n1);
         win = (r0 && r1) ? ~mdl_last : r1;
         exp_q.push_back({win, win ? tab1[i1] : tab0[i0]});
         run = 0; n = 0; seen0 = 0; seen1 = 0;
         while (!seen0 && !seen1 && n < 3 * FRAME_CYC) begin
            @(negedge sysclk);
            n++;
            if (busy === 1'b0) run++;
            else run = 0;
            seen0 = (ack0 === 1'b1);
            seen1 = (ack1 === 1'b1);
         end
         checks++;
         if (seen0 == seen1 || seen1 != win) begin
            errors++;
            $display("FAIL grant_%0d: ack0=%b ack1=%b, required ack%0d only", g, ack0, ack1, win);
            if (!seen0 && !seen1) begin
               void'(exp_q.pop_back());
               req0 = 1'b0; req1 = 1'b0;
               return;
            end
         end
         if (g > 0) begin
            checks++;
            if (run != 2) begin
               errors++;
               $display("FAIL idle_gap_%0d: %0d busy-low cycles up to ack, required 2", g, run);
            end
         end
         mdl_last = win;
         @(posedge sysclk); #2;
         if (win) begin
            i1++;
            if (i1 < n1) data1 = tab1[i1];
            else req1 = 1'b0;
         end else begin
            i0++;
            if (i0 < n0) data0 = tab0[i0];
            else req0 = 1'b0;
         end
         @(negedge sysclk);
         checks++;
         if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
            errors++;
            $display("FAIL ack_width_%0d: ack0=%b ack1=%b one cycle after grant, required 0 0", g, ack0, ack1);
         end
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy !== 1'b0 || exp_q.size() != 0) && n < 3 * FRAME_CYC) begin
         @(negedge sysclk);
         n++;
      end
      checks++;
      if (busy !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: busy=%b pending frames=%0d, required 0 and 0", busy, exp_q.size());
      end
      repeat (3) @(negedge sysclk);
   endtask

   // Scenarios.
   task automatic test_reset();
      reset = 1'b1; req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
      for (int i = 0; i < 3; i++) begin
         @(posedge sysclk); #2;
         checks++;
         if (tx !== 1'b1 || busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0 || owner !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_%0d: tx=%b busy=%b ack0=%b ack1=%b owner=%b, required 1 0 0 0 0",
                     i, tx, busy, ack0, ack1, owner);
         end
      end
      req0 = 1'b0; req1 = 1'b0; reset = 1'b0;
      mdl_last = 1'b1;
      repeat (2) @(posedge sysclk);
      #2;
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_req: tx=%b busy=%b ack0=%b ack1=%b, required 1 0 0 0", tx, busy, ack0, ack1);
      end
   endtask

   task automatic test_single();
      tab0[0] = 8'h55;
      serve(1, 0);
      wait_idle();
   endtask

   task automatic test_simultaneous();
      reset_dut();
      tab0[0] = 8'hA5;
      tab1[0] = 8'h3C;
      serve(1, 1);
      wait_idle();
   endtask

   task automatic test_back_to_back();
      tab0[0] = 8'hC3; tab0[1] = 8'h0F;
      tab1[0] = 8'h81; tab1[1] = 8'hE7;
      serve(2, 2);
      wait_idle();
   endtask

   task automatic test_reset_abort();
      int n;
      @(posedge sysclk); #2;
      req0 = 1'b1; data0 = 8'h96;
      n = 0;
      while (ack0 !== 1'b1 && n < 3 * FRAME_CYC) begin
         @(negedge sysclk);
         n++;
      end
      @(posedge sysclk); #2 req0 = 1'b0;
      n = 0;
      while (tx !== 1'b0 && n < 4 * BIT_CYC) begin
         @(negedge sysclk);
         n++;
      end
      // Middle of data bit 3 (frame bit 4).
      repeat (BIT_CYC / 2 + 4 * BIT_CYC) @(negedge sysclk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_precondition: busy=%b in data bit 3, required 1", busy);
      end
      @(posedge sysclk); #2 reset = 1'b1;
      @(posedge sysclk); #2;
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0 || owner !== 1'b0) begin
         errors++;
         $display("FAIL abort_state: tx=%b busy=%b ack0=%b ack1=%b owner=%b, required 1 0 0 0 0",
                  tx, busy, ack0, ack1, owner);
      end
      reset = 1'b0;
      mdl_last = 1'b1;
      tab1[0] = 8'hFF;
      serve(0, 1);
      wait_idle();
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      tab0[0] = 8'h07;
      serve(1, 0);
      wait_idle();
      tab0[0] = 8'h03;
      serve(1, 0);
      wait_idle();
   endtask
`endif

   task automatic test_random();
      int n0, n1;
      for (int r = 0; r < 2; r++) begin
         n0 = $urandom_range(1, 2);
         n1 = $urandom_range(0, 2);
         for (int i = 0; i < 4; i++) begin
            tab0[i] = DB'($urandom_range(0, 255));
            tab1[i] = DB'($urandom_range(0, 255));
         end
         serve(n0, n1);
         wait_idle();
      end
   endtask

   initial begin
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
      mdl_last = 1'b1;
      test_reset();
      test_single();
      test_simultaneous();
      test_back_to_back();
      test_reset_abort();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
